minimig_reset_seq: RTL
======================

# minimig_reset_seq

Parametrised reset sequencer for the minimig core. It replaces the single-output reset timer with several ordered reset domains and multiple reset-request sources. It adds cold/warm reset tracking and a boot flag that is cleared by the bootloader's bootdone strobe, which also forces one warm reset. It sits at the top of the core, clocked by the bus clock, and drives the synchronous resets of CPU, chipset and peripheral domains.

## Interface
Parameters:
- NSRC, 2: number of reset-request inputs.
- NOUT, 3: number of reset domains. Released in index order 0..NOUT-1.
- HOLD_CNT, 4: `cnt` pulses that must be counted with no request active before domain 0 is released. Must be ≥1.
- STAGE_CNT, 2: `cnt` pulses between successive domain releases. Must be ≥1.

Ports:
- clk  in  1  bus clock.
- reset_n  in  1  asynchronous, active-low power-on reset.
- clk7_en  in  1  clock enable. All state changes happen only on `clk` edges where this is high.
- cnt  in  1  counting pulse. Sampled only when `clk7_en` is high.
- rst_req  in  NSRC  level reset requests (user reset, keyboard reset, …). Any bit high means a request is active.
- bootdone  in  1  single-cycle strobe from the bootloader. Sampled with `clk7_en`.
- reset_out  out  NOUT  active-high synchronous domain resets.
- boot  out  1  high from power-on until the first accepted `bootdone`.
- cold  out  1  high until the first entry to RUN after power-on.
- busy  out  1  high whenever the state is not RUN.

## Operation
- **States:** HOLD, RELEASE, RUN. The enum is shared through the package.
- **Power-on (`reset_n` low):** state=HOLD, hold counter=0, stage counter=0, stage index=0, reset_out=all 1, boot=1, cold=1, busy=1.
- **HOLD:**
  - While any `rst_req` bit is high, or `bootdone` is accepted, the hold counter is forced to 0.
  - Otherwise each `cnt` pulse increments it.
  - When an increment makes it equal HOLD_CNT:
    - reset_out[0] is cleared.
    - If NOUT==1, go to RUN.
    - Otherwise go to RELEASE with index=1 and stage counter=0.
- **RELEASE:**
  - Each `cnt` pulse increments the stage counter.
  - When it reaches STAGE_CNT: clear reset_out[index], reset the stage counter to 0, and increment the index.
  - If the released index was NOUT-1, go to RUN.
- **RUN:** busy=0, cold=0. All reset_out bits are low.
- **Request in RELEASE or RUN:** on the same enabled edge, go to HOLD. reset_out=all 1, all counters=0, index=0. `cold` is unchanged, so this is a warm reset.
- **bootdone:**
  - Accepted only when boot=1. On acceptance: boot←0, and the block behaves exactly as a request (enters/stays in HOLD, counters cleared).
  - Ignored when boot=0.
  - Nothing other than `reset_n` sets boot again.
- **Counters:** the hold counter is $clog2(HOLD_CNT+1) bits and the stage counter is $clog2(STAGE_CNT+1) bits. Neither can exceed its terminal value. The index is $clog2(NOUT+1) bits.

## Timing
- **Request to all-domains-reset:** reset_out is all 1 on the first enabled edge that samples the request high. Latency is 1 enabled cycle.
- **Release:** reset_out[0] falls on the enabled edge that samples the HOLD_CNT-th qualifying `cnt`. Domain k falls k·STAGE_CNT further `cnt` pulses later.
- **Total, request-low to RUN:** HOLD_CNT+(NOUT-1)·STAGE_CNT `cnt` pulses.
- **Request held high:** the block stays in HOLD indefinitely. `cnt` pulses during that time are discarded.
- **Request and `cnt` on the same edge in HOLD:** the clear wins.
- **Request and a release on the same edge:** the request wins. No bit is released.
- **`bootdone` and a request on the same edge:** both take effect, with boot←0 and the state going to HOLD.
- **`cnt` or `bootdone` with clk7_en=0:** ignored.
- **`reset_n` assertion at any time:** immediate return to power-on values, including boot=1 and cold=1.
- **All outputs are registered.** There is no combinational path from inputs to outputs.

## Structure
- **Package `minimig_reset_pkg`:** the state enum (HOLD, RELEASE, RUN) and a width helper function for the counters.
- **Sub-module `minimig_pulse_cnt`:** an enable-qualified, clearable, saturating pulse counter with a terminal-count flag. It is instantiated twice, once for the hold counter and once for the stage counter.

## Test plan
- **Power-on, defaults:** reset_n low→high, no requests, `cnt` on every 4th enabled cycle.
  - reset_out=111 through 4 pulses.
  - Then 110 at pulse 4, 100 at pulse 6, 000 at pulse 8.
  - busy falls at pulse 8, cold falls at pulse 8, boot stays 1.
- **bootdone:** a `bootdone` strobe in RUN gives reset_out=111 on the next enabled edge and boot=0. The 8-pulse release sequence repeats and cold stays 0. A second `bootdone` is ignored, and reset_out stays 000.
- **Request mid-release:** rst_req[1] pulses high after reset_out=110.
  - reset_out returns to 111 and the hold counter restarts from 0.
  - The full 8-pulse sequence follows the request falling.
- **Request held / clock enable:**
  - rst_req[0] held high for 20 `cnt` pulses: no release occurs.
  - `cnt` pulses with clk7_en=0: no count.
- **Simultaneous events:**
  - rst_req and the 4th `cnt` pulse on the same enabled edge: reset_out stays 111 and the counter is 0.
  - `bootdone` together with rst_req: boot=0 and the state is HOLD.
- **Edge parameters:**
  - NOUT=1, HOLD_CNT=1: reset_out falls on the first `cnt` after requests clear, and busy falls on the same edge.
  - Asynchronous reset_n asserted in RUN: all outputs return to power-on values without any clock edge.

Source files
------------

// File: rtl/minimig_reset_pkg.sv
// Shared types and helpers for the minimig reset sequencer.
package minimig_reset_pkg;

   typedef enum logic [1:0] {
      HOLD,
      RELEASE,
      RUN
   } rst_state_t;

   // Bits needed to hold 0..n inclusive.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/minimig_reset_seq_if.sv
// Request/strobe inputs and domain-reset outputs of the reset sequencer.
interface minimig_reset_seq_if #(
   parameter int NSRC = 2,
   parameter int NOUT = 3
);
   logic            clk7_en;
   logic            cnt;
   logic [NSRC-1:0] rst_req;
   logic            bootdone;
   logic [NOUT-1:0] reset_out;
   logic            boot;
   logic            cold;
   logic            busy;

   modport master (
      output clk7_en, cnt, rst_req, bootdone,
      input  reset_out, boot, cold, busy
   );

   modport slave (
      input  clk7_en, cnt, rst_req, bootdone,
      output reset_out, boot, cold, busy
   );
endinterface

// File: rtl/minimig_pulse_cnt.sv
// Enable-qualified, clearable, saturating pulse counter.
// tc flags the pulse that brings the count to TERM.
module minimig_pulse_cnt
   import minimig_reset_pkg::*;
#(
   parameter int TERM = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   input  logic inc,
   output logic tc
);
   localparam int W = cnt_w(TERM);

   logic [W-1:0] count;

   assign tc = en & inc & (count == W'(TERM - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (en) begin
         if (clr)
            count <= '0;
         else if (inc && count != W'(TERM))
            count <= count + W'(1);
      end
   end
endmodule

// File: rtl/minimig_reset_seq.sv
// Ordered multi-domain reset sequencer with cold/warm tracking and
// a boot flag cleared by the bootloader's bootdone strobe.
module minimig_reset_seq
   import minimig_reset_pkg::*;
#(
   parameter int NSRC      = 2,
   parameter int NOUT      = 3,
   parameter int HOLD_CNT  = 4,
   parameter int STAGE_CNT = 2
) (
   input logic               clk,
   input logic               reset_n,
   minimig_reset_seq_if.slave bus
);
   localparam int IW = cnt_w(NOUT);

   rst_state_t      state;
   logic [IW-1:0]   idx;
   logic [NOUT-1:0] ro_q;
   logic            boot_q;
   logic            cold_q;
   logic            busy_q;

   logic en;
   logic boot_acc;
   logic req;
   logic hold_tc;
   logic stage_tc;

   assign en       = bus.clk7_en;
   assign boot_acc = bus.bootdone & boot_q;
   assign req      = (|bus.rst_req) | boot_acc;

   minimig_pulse_cnt #(.TERM(HOLD_CNT)) u_hold (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .clr     (req),
      .inc     (bus.cnt & (state == HOLD)),
      .tc      (hold_tc)
   );

   minimig_pulse_cnt #(.TERM(STAGE_CNT)) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .clr     (req | stage_tc),
      .inc     (bus.cnt & (state == RELEASE)),
      .tc      (stage_tc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= HOLD;
         idx    <= '0;
         ro_q   <= '1;
         boot_q <= 1'b1;
         cold_q <= 1'b1;
         busy_q <= 1'b1;
      end else if (en) begin
         if (boot_acc)
            boot_q <= 1'b0;
         // A request overrides any release due on the same edge.
         if (req) begin
            state  <= HOLD;
            idx    <= '0;
            ro_q   <= '1;
            busy_q <= 1'b1;
         end else begin
            unique case (state)
               HOLD: begin
                  if (hold_tc) begin
                     ro_q <= ro_q & ~NOUT'(1);
                     if (NOUT == 1) begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                        cold_q <= 1'b0;
                     end else begin
                        state <= RELEASE;
                        idx   <= IW'(1);
                     end
                  end
               end
               RELEASE: begin
                  if (stage_tc) begin
                     ro_q <= ro_q & ~(NOUT'(1) << idx);
                     idx  <= idx + IW'(1);
                     if (int'(idx) == NOUT - 1) begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                        cold_q <= 1'b0;
                     end
                  end
               end
               RUN: begin
                  ro_q <= '0;
               end
               default: begin
                  state <= HOLD;
               end
            endcase
         end
      end
   end

   assign bus.reset_out = ro_q;
   assign bus.boot      = boot_q;
   assign bus.cold      = cold_q;
   assign bus.busy      = busy_q;
endmodule
